// File: rtl/rgmii_ibs_monitor.sv
// Multi-channel RGMII in-band status monitor: debounces inter-frame status nibbles
// into committed link state, sticky change flags, maskable level interrupt, flap counters.
// Latency: commit on the edge of the DEBOUNCE-th equal valid sample; interrupt one cycle later.
// Optional build macro RGMII_IBS_FLAP_CNT_EN enables the per-channel link-flap counters.
module rgmii_ibs_monitor #(
  parameter int CHANNELS = 1,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*CHANNELS-1:0]     rxd,
  input  logic [CHANNELS-1:0]       rxdv,
  input  logic [CHANNELS-1:0]       rxer,
  input  logic [CHANNELS-1:0]       irq_mask,
  input  logic [CHANNELS-1:0]       irq_clr,
  output logic [CHANNELS-1:0]       link_up,
  output logic [2*CHANNELS-1:0]     link_spd,
  output logic [CHANNELS-1:0]       link_dplx,
  output logic [CHANNELS-1:0]       change_sts,
  output logic                      interrupt,
  output logic [CNT_W*CHANNELS-1:0] flap_cnt
);

  localparam logic [7:0] DEB = 8'(DEBOUNCE);

  // Status nibble layout everywhere: {dplx, spd[1:0], up}
  logic [CHANNELS-1:0][3:0] cand_q, cand_d;
  logic [CHANNELS-1:0][7:0] run_q, run_d;
  logic [CHANNELS-1:0][3:0] stat_q, stat_d;
  logic [CHANNELS-1:0]      chg_q, chg_d;
  logic                     irq_q, irq_d;
  logic [CHANNELS-1:0]      commit;
  logic [3:0]               smp;
  logic                     vld;

  // Only the low nibble of each channel carries status; the rest is frame data.
  logic unused_rxd;
  assign unused_rxd = ^rxd;

  // Debounce each channel's status nibble and decide commits / sticky flags
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    stat_d = stat_q;
    chg_d  = chg_q;
    commit = '0;
    smp    = '0;
    vld    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      smp = rxd[8*i +: 4];
      vld = ~rxdv[i] & ~rxer[i];
      if (vld) begin
        if (smp != cand_q[i]) begin
          cand_d[i] = smp;
          run_d[i]  = 8'd1;
        end else if (run_q[i] != DEB) begin
          run_d[i]  = run_q[i] + 8'd1;
        end
      end
      // A fresh run (differing sample) may commit even if the old run sat at DEB,
      // which is what makes DEBOUNCE=1 commit on a single sample.
      commit[i] = vld && (run_d[i] == DEB) &&
                  ((smp != cand_q[i]) || (run_q[i] != DEB)) &&
                  (cand_d[i] != stat_q[i]);
      if (commit[i]) begin
        stat_d[i] = cand_d[i];
        chg_d[i]  = 1'b1;
      end else if (irq_clr[i]) begin
        chg_d[i]  = 1'b0;
      end
    end
    irq_d = |(chg_q & ~irq_mask);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q <= '0;
      run_q  <= '0;
      stat_q <= '0;
      chg_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
      stat_q <= stat_d;
      chg_q  <= chg_d;
      irq_q  <= irq_d;
    end
  end

  // Unpack committed status onto the output buses
  always_comb begin
    link_up   = '0;
    link_spd  = '0;
    link_dplx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      link_up[i]         = stat_q[i][0];
      link_spd[2*i +: 2] = stat_q[i][2:1];
      link_dplx[i]       = stat_q[i][3];
    end
  end

  assign change_sts = chg_q;
  assign interrupt  = irq_q;

`ifdef RGMII_IBS_FLAP_CNT_EN
  logic [CHANNELS-1:0][CNT_W-1:0] flap_q, flap_d;

  // Count commits that change link_up, saturating at all-ones
  always_comb begin
    flap_d = flap_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (commit[i] && (cand_d[i][0] != stat_q[i][0]) && (flap_q[i] != '1)) begin
        flap_d[i] = flap_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Flap counter registers, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flap_q <= '0;
    else       flap_q <= flap_d;
  end

  assign flap_cnt = flap_q;
`else
  assign flap_cnt = '0;
`endif

endmodule

// File: tb/tb_rgmii_ibs_monitor.sv
// Randomized + directed bench for rgmii_ibs_monitor (2 channels, DEBOUNCE=4, CNT_W=2)
// against a history-based reference model of the status qualification rules.
module tb_rgmii_ibs_monitor;
  localparam int CH  = 2;
  localparam int DEB = 4;
  localparam int CW  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [8*CH-1:0] rxd = '0;
  logic [CH-1:0]   rxdv = '0, rxer = '0, irq_mask = '0, irq_clr = '0;
  logic [CH-1:0]   link_up, link_dplx, change_sts;
  logic [2*CH-1:0] link_spd;
  logic            interrupt;
  logic [CW*CH-1:0] flap_cnt;

  rgmii_ibs_monitor #(.CHANNELS(CH), .DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rxdv(rxdv), .rxer(rxer),
    .irq_mask(irq_mask), .irq_clr(irq_clr), .link_up(link_up), .link_spd(link_spd),
    .link_dplx(link_dplx), .change_sts(change_sts), .interrupt(interrupt),
    .flap_cnt(flap_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per channel the newest valid samples since reset (index 0 newest).
  // A new status is qualified when exactly DEB trailing valid samples agree.
  logic [3:0] hbuf [CH][DEB+1];
  int         hcnt [CH];
  logic [3:0] m_stat [CH];
  int         m_flap [CH];
  logic [CH-1:0] m_chg;
  logic          m_irq;

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      hcnt[c] = 0; m_stat[c] = 4'h0; m_flap[c] = 0;
      for (int k = 0; k <= DEB; k++) hbuf[c][k] = 4'h0;
    end
    m_chg = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [CH-1:0] chg_old;
    logic [3:0] s;
    int n;
    bit commit;
    chg_old = m_chg;
    m_irq = |(chg_old & ~irq_mask);
    for (int c = 0; c < CH; c++) begin
      commit = 0;
      if (!rxdv[c] && !rxer[c]) begin
        s = rxd[8*c +: 4];
        for (int k = DEB; k > 0; k--) hbuf[c][k] = hbuf[c][k-1];
        hbuf[c][0] = s;
        if (hcnt[c] < DEB + 1) hcnt[c]++;
        n = 0;
        while (n < hcnt[c] && hbuf[c][n] == s) n++;
        commit = (n == DEB) && (s != m_stat[c]);
        if (commit) begin
`ifdef RGMII_IBS_FLAP_CNT_EN
          if (s[0] != m_stat[c][0] && m_flap[c] < (1 << CW) - 1) m_flap[c]++;
`endif
          m_stat[c] = s;
        end
      end
      m_chg[c] = commit ? 1'b1 : (irq_clr[c] ? 1'b0 : chg_old[c]);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [CH-1:0] eu, ed;
    logic [2*CH-1:0] es;
    logic [CW*CH-1:0] ef;
    for (int c = 0; c < CH; c++) begin
      eu[c] = m_stat[c][0];
      es[2*c +: 2] = m_stat[c][2:1];
      ed[c] = m_stat[c][3];
      ef[CW*c +: CW] = CW'(m_flap[c]);
    end
    chk({tag, "_up"},   64'(link_up),    64'(eu));
    chk({tag, "_spd"},  64'(link_spd),   64'(es));
    chk({tag, "_dplx"}, 64'(link_dplx),  64'(ed));
    chk({tag, "_chg"},  64'(change_sts), 64'(m_chg));
    chk({tag, "_irq"},  64'(interrupt),  64'(m_irq));
    chk({tag, "_flap"}, 64'(flap_cnt),   64'(ef));
  endtask

  // One clock: apply inputs, advance model, check after the edge.
  // Upper nibbles carry random data that must be ignored.
  task automatic cyc(input logic [3:0] n0, input logic [3:0] n1,
                     input logic [1:0] dv, input logic [1:0] er,
                     input logic [1:0] msk, input logic [1:0] clr);
    rxd      = {4'($urandom_range(15)), n1, 4'($urandom_range(15)), n0};
    rxdv     = dv;
    rxer     = er;
    irq_mask = msk;
    irq_clr  = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    chk({tag, "_up"},   64'(link_up),    64'(0));
    chk({tag, "_spd"},  64'(link_spd),   64'(0));
    chk({tag, "_dplx"}, 64'(link_dplx),  64'(0));
    chk({tag, "_chg"},  64'(change_sts), 64'(0));
    chk({tag, "_irq"},  64'(interrupt),  64'(0));
    chk({tag, "_flap"}, 64'(flap_cnt),   64'(0));
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [CW-1:0] exp_sat;
  logic [3:0] rn [CH];
  logic [1:0] rmsk;

  initial begin
`ifdef RGMII_IBS_FLAP_CNT_EN
    exp_sat = '1;
`else
    exp_sat = '0;
`endif
    model_clear();
    #3;
    do_reset("rst0");

    // Link comes up at 1000M full on ch0
    for (int k = 0; k < DEB; k++) cyc(4'hD, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("tp_up",   64'(link_up),       64'(2'b01));
    chk("tp_spd",  64'(link_spd[1:0]), 64'(2'b10));
    chk("tp_dplx", 64'(link_dplx[0]),  64'(1));
    chk("tp_chg",  64'(change_sts),    64'(2'b01));
    chk("tp_irq_lag", 64'(interrupt),  64'(0));
    cyc(4'hD, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("tp_irq",  64'(interrupt),     64'(1));
    chk("tp_flap", 64'(flap_cnt[CW-1:0]), 64'(exp_sat == 0 ? 0 : 1));

    // Short glitch never commits
    for (int k = 0; k < 3; k++) cyc(4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < DEB; k++) cyc(4'hD, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("glitch_up", 64'(link_up), 64'(2'b01));
    chk("glitch_flap", 64'(flap_cnt[CW-1:0]), 64'(exp_sat == 0 ? 0 : 1));

    // Valid 4'h3 samples interleaved with frames, errors and carrier extend
    cyc(4'h3, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(4'($urandom_range(15)), 4'h0, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(4'($urandom_range(15)), 4'h0, 2'b01, 2'b01, 2'b00, 2'b00);
    cyc(4'h3, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(4'hF, 4'h0, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc(4'h3, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(4'($urandom_range(15)), 4'h0, 2'b01, 2'b00, 2'b00, 2'b00);
    chk("ilv_pre_spd", 64'(link_spd[1:0]), 64'(2'b10));
    cyc(4'h3, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("ilv_spd",  64'(link_spd[1:0]), 64'(2'b01));
    chk("ilv_dplx", 64'(link_dplx[0]),  64'(0));
    chk("ilv_up",   64'(link_up[0]),    64'(1));

    // Clear flag, then masked commit, unmask, clear coincident with commit
    cyc(4'h3, 4'h0, 2'b00, 2'b00, 2'b00, 2'b01);
    chk("clr_chg", 64'(change_sts), 64'(0));
    for (int k = 0; k < DEB; k++) cyc(4'hD, 4'h0, 2'b00, 2'b00, 2'b01, 2'b00);
    cyc(4'hD, 4'h0, 2'b00, 2'b00, 2'b01, 2'b00);
    chk("mask_chg", 64'(change_sts), 64'(2'b01));
    chk("mask_irq", 64'(interrupt),  64'(0));
    cyc(4'hD, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("unmask_irq", 64'(interrupt), 64'(1));
    for (int k = 0; k < DEB - 1; k++) cyc(4'h3, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(4'h3, 4'h0, 2'b00, 2'b00, 2'b00, 2'b01);
    chk("setwin_chg", 64'(change_sts), 64'(2'b01));

    // Five link_up toggles saturate the 2-bit counter
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < DEB; k++)
        cyc((t % 2 == 0) ? 4'h0 : 4'h1, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("flap_sat", 64'(flap_cnt[CW-1:0]), 64'(exp_sat));

    // Reset mid-qualification on ch1 discards the partial run
    cyc(4'h0, 4'h5, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(4'h0, 4'h5, 2'b00, 2'b00, 2'b00, 2'b00);
    do_reset("rst_mid");
    for (int k = 0; k < DEB - 1; k++) cyc(4'h0, 4'h5, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("rst_requal_pre", 64'(link_up[1]), 64'(0));
    cyc(4'h0, 4'h5, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("rst_requal", 64'(link_up[1]), 64'(1));

    // Randomized run: sticky per-channel status with occasional changes
    rn[0] = 4'hD; rn[1] = 4'h5; rmsk = 2'b00;
    for (int i = 0; i < 800; i++) begin
      logic [1:0] dv, er, clr;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(6) == 0) rn[c] = 4'($urandom_range(15));
      dv = 2'($urandom_range(3) & $urandom_range(3));
      er = 2'($urandom_range(3) & $urandom_range(3) & $urandom_range(3));
      clr = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b00;
      if ($urandom_range(15) == 0) rmsk = 2'($urandom_range(3));
      if (i == 400) do_reset("rst_rand");
      cyc(rn[0], rn[1], dv, er, rmsk, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
